// File: rtl/vga_rx.sv
// -----------------------------------------------------------------------------
// vga_rx
// Captures a VGA-style pixel stream into frame-memory write transactions and
// measures the incoming active-video geometry.
//
// Ports
//   i_clk            pixel clock, all logic on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_vga_hsync      active-low horizontal sync (registered, not needed for
//                    capture: line boundaries come from blank_n falling)
//   i_vga_vsync      active-low vertical sync, falling edge starts a frame
//   i_vga_blank_n    high while the pixel is active video
//   i_vga_r/g/b      8-bit colour components
//   o_wr_en          frame-memory write strobe
//   o_wr_h_addr      write column
//   o_wr_v_addr      write row
//   o_wr_data        {r,g,b}, r in [23:16]
//   o_frame_done     one-cycle pulse when a captured frame ends
//   o_h_active       width measured on the last completed frame
//   o_v_active       height measured on the last completed frame
//   o_locked         geometry has been stable for consecutive frames
//   o_err            sticky overflow / line-width mismatch flag
// -----------------------------------------------------------------------------
module vga_rx #(
  parameter int H_MAX = 640,
  parameter int V_MAX = 480
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vga_hsync,
  input  logic        i_vga_vsync,
  input  logic        i_vga_blank_n,
  input  logic [7:0]  i_vga_r,
  input  logic [7:0]  i_vga_g,
  input  logic [7:0]  i_vga_b,
  output logic        o_wr_en,
  output logic [9:0]  o_wr_h_addr,
  output logic [8:0]  o_wr_v_addr,
  output logic [23:0] o_wr_data,
  output logic        o_frame_done,
  output logic [9:0]  o_h_active,
  output logic [9:0]  o_v_active,
  output logic        o_locked,
  output logic        o_err
);

  localparam logic [9:0] H_LIM = 10'(H_MAX);
  localparam logic [9:0] V_LIM = 10'(V_MAX);

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  // Counter increment that sticks at its limit instead of wrapping.
  function automatic logic [9:0] sat_inc(input logic [9:0] cnt,
                                         input logic [9:0] lim);
    logic [9:0] res;
    if (cnt >= lim) res = lim;
    else            res = cnt + 10'd1;
    return res;
  endfunction

  // Saturating 2-bit frame-match counter, tops out at 2.
  function automatic logic [1:0] sat_match(input logic [1:0] cnt);
    logic [1:0] res;
    if (cnt >= 2'd2) res = 2'd2;
    else             res = cnt + 2'd1;
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p1: every input registered once
  // ---------------------------------------------------------------------------
  logic        unused_hsync_p1;
  logic        vsync_p1;
  logic        vld_p1;
  logic [23:0] rgb_p1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      unused_hsync_p1 <= 1'b0;
      vsync_p1        <= 1'b0;
      vld_p1          <= 1'b0;
      rgb_p1          <= 24'd0;
    end else begin
      unused_hsync_p1 <= i_vga_hsync;
      vsync_p1        <= i_vga_vsync;
      vld_p1          <= i_vga_blank_n;
      rgb_p1          <= {i_vga_r, i_vga_g, i_vga_b};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: delayed copy used only for edge detection against p1
  // ---------------------------------------------------------------------------
  logic vsync_p2;
  logic vld_p2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync_p2 <= 1'b0;
      vld_p2   <= 1'b0;
    end else begin
      vsync_p2 <= vsync_p1;
      vld_p2   <= vld_p1;
    end
  end

  logic vs_start;
  logic eol;

  assign vs_start = vsync_p2 & ~vsync_p1;
  assign eol      = vld_p2 & ~vld_p1;

  // ---------------------------------------------------------------------------
  // Capture control and output stage
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [9:0]  cur_w_q, cur_w_d;
  logic [1:0]  match_q, match_d;

  logic        wr_en_d;
  logic [9:0]  wr_h_d;
  logic [8:0]  wr_v_d;
  logic [23:0] wr_data_d;
  logic        frame_done_d;
  logic [9:0]  h_act_d;
  logic [9:0]  v_act_d;
  logic        locked_d;
  logic        err_d;

  // Line-level results, applied before any frame-level update so that a
  // vsync landing on the same cycle as an end of line sees the finished line.
  logic [9:0]  v_line;
  logic [9:0]  w_line;
  logic [1:0]  match_line;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    cur_w_d      = cur_w_q;
    match_d      = match_q;
    wr_en_d      = 1'b0;
    wr_h_d       = o_wr_h_addr;
    wr_v_d       = o_wr_v_addr;
    wr_data_d    = o_wr_data;
    frame_done_d = 1'b0;
    h_act_d      = o_h_active;
    v_act_d      = o_v_active;
    err_d        = o_err;
    v_line       = v_cnt_q;
    w_line       = cur_w_q;
    match_line   = match_q;

    case (state_q)
      IDLE: begin
        h_cnt_d = 10'd0;
        v_cnt_d = 10'd0;
        // The vsync that opens the first frame has no finished frame behind
        // it, so nothing is reported here.
        if (vs_start) state_d = CAPTURE;
      end

      CAPTURE: begin
        if (vld_p1) begin
          if ((h_cnt_q < H_LIM) && (v_cnt_q < V_LIM)) begin
            wr_en_d   = 1'b1;
            wr_h_d    = h_cnt_q;
            wr_v_d    = v_cnt_q[8:0];
            wr_data_d = rgb_p1;
          end else begin
            err_d = 1'b1;
          end
          h_cnt_d = sat_inc(h_cnt_q, H_LIM);
        end

        if (eol) begin
          h_cnt_d = 10'd0;
          v_line  = sat_inc(v_cnt_q, V_LIM);
          // First line of the frame defines the reference width.
          if (v_cnt_q == 10'd0) begin
            w_line = h_cnt_q;
          end else if (h_cnt_q != cur_w_q) begin
            err_d      = 1'b1;
            match_line = 2'd0;
          end
        end

        v_cnt_d = v_line;
        cur_w_d = w_line;
        match_d = match_line;

        if (vs_start) begin
          v_cnt_d      = 10'd0;
          frame_done_d = 1'b1;
          h_act_d      = w_line;
          v_act_d      = v_line;
          if ((w_line == o_h_active) && (v_line == o_v_active) &&
              (w_line != 10'd0) && (v_line != 10'd0)) begin
            match_d = sat_match(match_line);
          end else begin
            match_d = 2'd0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    locked_d = (match_d == 2'd2);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_q      <= 10'd0;
      v_cnt_q      <= 10'd0;
      cur_w_q      <= 10'd0;
      match_q      <= 2'd0;
      o_wr_en      <= 1'b0;
      o_wr_h_addr  <= 10'd0;
      o_wr_v_addr  <= 9'd0;
      o_wr_data    <= 24'd0;
      o_frame_done <= 1'b0;
      o_h_active   <= 10'd0;
      o_v_active   <= 10'd0;
      o_locked     <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      cur_w_q      <= cur_w_d;
      match_q      <= match_d;
      o_wr_en      <= wr_en_d;
      o_wr_h_addr  <= wr_h_d;
      o_wr_v_addr  <= wr_v_d;
      o_wr_data    <= wr_data_d;
      o_frame_done <= frame_done_d;
      o_h_active   <= h_act_d;
      o_v_active   <= v_act_d;
      o_locked     <= locked_d;
      o_err        <= err_d;
    end
  end

endmodule
